// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Single outstanding level-hold fetch, one-entry skid buffer for stalls, redirect flush.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_DISCARD  = 2'd1,
    S_BUFFERED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_fetch_addr;
  logic [31:0] w_fetch_addr_next;
  logic [31:0] r_pend_pc;
  logic [31:0] w_pend_pc_next;
  logic [31:0] r_buf;
  logic [31:0] w_buf_next;
  logic [31:0] r_buf_pc;
  logic [31:0] w_buf_pc_next;
  logic        r_buf_valid;
  logic        w_buf_valid_next;

  logic        r_id_valid;
  logic        w_id_valid_next;
  logic [31:0] r_id_inst;
  logic [31:0] w_id_inst_next;
  logic [31:0] r_id_pc;
  logic [31:0] w_id_pc_next;
  logic [31:0] r_id_pc_plus4;
  logic [31:0] w_id_pc_plus4_next;

  logic        w_load;
  logic [31:0] w_load_inst;
  logic [31:0] w_load_pc;
  logic [31:0] w_redirect_tgt;
  logic [31:0] w_fetch_addr_plus4;
  logic        w_unused;

  assign w_redirect_tgt     = {redirect_pc[31:2], 2'b00};
  assign w_fetch_addr_plus4 = r_fetch_addr + 32'd4;
  assign w_unused           = ^redirect_pc[1:0];

  // The request is a level driven from state; reset forces it low in the same cycle.
  assign imem_req    = !rst && (r_state != S_BUFFERED);
  assign imem_addr   = r_fetch_addr;
  assign id_valid    = r_id_valid;
  assign id_inst     = r_id_inst;
  assign id_pc       = r_id_pc;
  assign id_pc_plus4 = r_id_pc_plus4;

  always_comb begin
    w_state_next       = r_state;
    w_fetch_addr_next  = r_fetch_addr;
    w_pend_pc_next     = r_pend_pc;
    w_buf_next         = r_buf;
    w_buf_pc_next      = r_buf_pc;
    w_buf_valid_next   = r_buf_valid;
    w_id_valid_next    = r_id_valid;
    w_id_inst_next     = r_id_inst;
    w_id_pc_next       = r_id_pc;
    w_id_pc_plus4_next = r_id_pc_plus4;
    w_load             = 1'b0;
    w_load_inst        = r_buf;
    w_load_pc          = r_buf_pc;

    case (r_state)
      S_FETCH: begin
        if (redirect_valid) begin
          if (imem_rvalid) begin
            w_fetch_addr_next = w_redirect_tgt;
          end else begin
            // Request still in flight: let it finish, then go to the target.
            w_pend_pc_next = w_redirect_tgt;
            w_state_next   = S_DISCARD;
          end
        end else if (imem_rvalid) begin
          w_fetch_addr_next = w_fetch_addr_plus4;
          if (!stall) begin
            w_load      = 1'b1;
            w_load_inst = imem_rdata;
            w_load_pc   = r_fetch_addr;
          end else begin
            w_buf_next       = imem_rdata;
            w_buf_pc_next    = r_fetch_addr;
            w_buf_valid_next = 1'b1;
            w_state_next     = S_BUFFERED;
          end
        end else if (!stall) begin
          w_id_valid_next = 1'b0;
          w_id_inst_next  = NOP_INST;
        end
      end

      S_DISCARD: begin
        if (imem_rvalid) begin
          w_fetch_addr_next = redirect_valid ? w_redirect_tgt : r_pend_pc;
          w_state_next      = S_FETCH;
        end else if (redirect_valid) begin
          w_pend_pc_next = w_redirect_tgt;
        end
      end

      S_BUFFERED: begin
        if (redirect_valid) begin
          w_buf_valid_next  = 1'b0;
          w_fetch_addr_next = w_redirect_tgt;
          w_state_next      = S_FETCH;
        end else if (!stall && r_buf_valid) begin
          w_load           = 1'b1;
          w_buf_valid_next = 1'b0;
          w_state_next     = S_FETCH;
        end
      end

      default: begin
        w_state_next = S_FETCH;
      end
    endcase

    if (w_load) begin
      w_id_valid_next    = 1'b1;
      w_id_inst_next     = w_load_inst;
      w_id_pc_next       = w_load_pc;
      w_id_pc_plus4_next = w_load_pc + 32'd4;
    end

    // Flush wins over stall and over any load decided above.
    if (redirect_valid) begin
      w_id_valid_next = 1'b0;
      w_id_inst_next  = NOP_INST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_fetch_addr  <= RESET_PC;
      r_pend_pc     <= RESET_PC;
      r_buf         <= NOP_INST;
      r_buf_pc      <= 32'd0;
      r_buf_valid   <= 1'b0;
      r_id_valid    <= 1'b0;
      r_id_inst     <= NOP_INST;
      r_id_pc       <= 32'd0;
      r_id_pc_plus4 <= 32'd0;
    end else begin
      r_state       <= w_state_next;
      r_fetch_addr  <= w_fetch_addr_next;
      r_pend_pc     <= w_pend_pc_next;
      r_buf         <= w_buf_next;
      r_buf_pc      <= w_buf_pc_next;
      r_buf_valid   <= w_buf_valid_next;
      r_id_valid    <= w_id_valid_next;
      r_id_inst     <= w_id_inst_next;
      r_id_pc       <= w_id_pc_next;
      r_id_pc_plus4 <= w_id_pc_plus4_next;
    end
  end

endmodule
